// File: rtl/fwd_sel_ctrl_if.sv
// fwd_sel_ctrl_if -- issue/forwarding bundle between the ID/EX stage logic and
// the fwd_sel_ctrl block.
//
//   iss_valid_i     ID presents an instruction for transfer into EX
//   iss_rs_i/rt_i   source registers of the issuing instruction
//   iss_rd_i        destination register of the issuing instruction
//   iss_regwrite_i  issuing instruction writes the register file
//   iss_memread_i   issuing instruction is a load
//   flush_i         kill instructions in ID and EX (branch taken)
//   hold_i          global freeze
//   stall_o         load-use stall request
//   fwd_a_o/fwd_b_o ALU operand mux selects (0 regfile, 1 EX/MEM, 2 MEM/WB)
//
// Optional (macro FWD_SEL_STAT_EN): stat_clr_i, stat_stall_o, stat_fwd_o.
// REG_AW must match the REG_AW of the fwd_sel_ctrl instance it connects to.
interface fwd_sel_ctrl_if #(
  parameter int REG_AW = 5
);
  logic              iss_valid_i;
  logic [REG_AW-1:0] iss_rs_i;
  logic [REG_AW-1:0] iss_rt_i;
  logic [REG_AW-1:0] iss_rd_i;
  logic              iss_regwrite_i;
  logic              iss_memread_i;
  logic              flush_i;
  logic              hold_i;
  logic              stall_o;
  logic [1:0]        fwd_a_o;
  logic [1:0]        fwd_b_o;
`ifdef FWD_SEL_STAT_EN
  logic              stat_clr_i;
  logic [15:0]       stat_stall_o;
  logic [15:0]       stat_fwd_o;

  modport master (
    output iss_valid_i, iss_rs_i, iss_rt_i, iss_rd_i, iss_regwrite_i,
           iss_memread_i, flush_i, hold_i, stat_clr_i,
    input  stall_o, fwd_a_o, fwd_b_o, stat_stall_o, stat_fwd_o
  );
  modport slave (
    input  iss_valid_i, iss_rs_i, iss_rt_i, iss_rd_i, iss_regwrite_i,
           iss_memread_i, flush_i, hold_i, stat_clr_i,
    output stall_o, fwd_a_o, fwd_b_o, stat_stall_o, stat_fwd_o
  );
`else
  modport master (
    output iss_valid_i, iss_rs_i, iss_rt_i, iss_rd_i, iss_regwrite_i,
           iss_memread_i, flush_i, hold_i,
    input  stall_o, fwd_a_o, fwd_b_o
  );
  modport slave (
    input  iss_valid_i, iss_rs_i, iss_rt_i, iss_rd_i, iss_regwrite_i,
           iss_memread_i, flush_i, hold_i,
    output stall_o, fwd_a_o, fwd_b_o
  );
`endif
endinterface

// File: rtl/fwd_sel_ctrl.sv
// fwd_sel_ctrl -- forwarding-select and load-use stall controller.
//
// Keeps a shadow copy of the EX, MEM and WB stage register info and derives
// the 2-bit ALU operand mux selects for the instruction currently in EX
// (0 = register file, 1 = EX/MEM result, 2 = MEM/WB result), plus a load-use
// stall request for the instruction presented by ID.
//
// Ports:
//   clk_i  clock
//   rst_i  synchronous, active-low reset
//   bus    fwd_sel_ctrl_if.slave (issue fields, flush/hold, stall/fwd outputs)
//
// Optional feature, enabled by defining FWD_SEL_STAT_EN: saturating 16-bit
// counters of stall edges and forwarding edges on bus.stat_stall_o /
// bus.stat_fwd_o, cleared by reset or bus.stat_clr_i.
module fwd_sel_ctrl #(
  parameter int REG_AW    = 5,
  parameter int NREG_ZERO = 0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  fwd_sel_ctrl_if.slave bus
);

  localparam logic [REG_AW-1:0] ZERO_REG = REG_AW'(NREG_ZERO);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } entry_t;

  entry_t ex_reg, mem_reg, wb_reg;
  entry_t ex_next, mem_next;
  entry_t iss_entry;
  logic   stall;

  assign iss_entry = '{valid:    1'b1,
                       rs:       bus.iss_rs_i,
                       rt:       bus.iss_rt_i,
                       rd:       bus.iss_rd_i,
                       regwrite: bus.iss_regwrite_i,
                       memread:  bus.iss_memread_i};

  // Load in EX whose destination is read by the issuing instruction.
  // Gated by rst_i so it is low throughout reset, and by flush_i because
  // the dependent instruction is being killed anyway.
  assign stall = rst_i & ~bus.flush_i & bus.iss_valid_i &
                 ex_reg.valid & ex_reg.memread & (ex_reg.rd != ZERO_REG) &
                 ((ex_reg.rd == bus.iss_rs_i) | (ex_reg.rd == bus.iss_rt_i));

  always_comb begin
    ex_next  = '0;
    mem_next = ex_reg;
    if (bus.iss_valid_i && !stall && !bus.flush_i) begin
      ex_next = iss_entry;
    end
    // A taken branch also kills the instruction leaving EX.
    if (bus.flush_i) begin
      mem_next = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_reg  <= '0;
      mem_reg <= '0;
      wb_reg  <= '0;
    end else if (!bus.hold_i) begin
      ex_reg  <= ex_next;
      mem_reg <= mem_next;
      wb_reg  <= mem_reg;
    end
  end

  // A stage can supply a result only if it really writes a non-zero register.
  logic mem_fwd_ok, wb_fwd_ok;
  assign mem_fwd_ok = mem_reg.valid & mem_reg.regwrite & (mem_reg.rd != ZERO_REG);
  assign wb_fwd_ok  = wb_reg.valid & wb_reg.regwrite & (wb_reg.rd != ZERO_REG);

  logic [REG_AW-1:0] src_reg [2];
  logic [1:0]        fwd_sel [2];

  assign src_reg[0] = ex_reg.rs;
  assign src_reg[1] = ex_reg.rt;

  // Operand 0 is A (rs), operand 1 is B (rt); MEM is younger so it wins.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      logic mem_hit, wb_hit;
      assign mem_hit = mem_fwd_ok & (mem_reg.rd == src_reg[gi]);
      assign wb_hit  = wb_fwd_ok & (wb_reg.rd == src_reg[gi]);
      assign fwd_sel[gi] = !ex_reg.valid ? 2'd0 :
                           mem_hit       ? 2'd1 :
                           wb_hit        ? 2'd2 : 2'd0;
    end
  endgenerate

  assign bus.stall_o = stall;
  assign bus.fwd_a_o = fwd_sel[0];
  assign bus.fwd_b_o = fwd_sel[1];

  // Source fields and load flag of the older stages are carried so each
  // shadow entry mirrors the real pipeline register, but nothing reads them.
  logic unused_fields;
  assign unused_fields = ^{mem_reg.rs, mem_reg.rt, mem_reg.memread,
                           wb_reg.rs, wb_reg.rt, wb_reg.memread};

`ifdef FWD_SEL_STAT_EN
  logic [15:0] stat_stall_reg, stat_fwd_reg;
  logic        fwd_any;

  assign fwd_any = (fwd_sel[0] != 2'd0) | (fwd_sel[1] != 2'd0);

  always_ff @(posedge clk_i) begin
    if (!rst_i || bus.stat_clr_i) begin
      stat_stall_reg <= '0;
      stat_fwd_reg   <= '0;
    end else if (!bus.hold_i) begin
      if (stall && stat_stall_reg != 16'hFFFF) begin
        stat_stall_reg <= stat_stall_reg + 16'd1;
      end
      if (fwd_any && stat_fwd_reg != 16'hFFFF) begin
        stat_fwd_reg <= stat_fwd_reg + 16'd1;
      end
    end
  end

  assign bus.stat_stall_o = stat_stall_reg;
  assign bus.stat_fwd_o   = stat_fwd_reg;
`endif

endmodule

// File: doc/fwd_sel_ctrl.md
Name: fwd_sel_ctrl

Overview:
- Generates the 2-bit operand-select codes that drive the pipeline's 3-to-1 ALU operand multiplexers.
- Select encoding: 0 = register-file data, 1 = EX/MEM result, 2 = MEM/WB result.
- Keeps its own shadow pipeline of destination-register info across the EX, MEM and WB stages.
- Detects load-use hazards and requests a one-cycle stall with bubble insertion. Sits beside the ID/EX register in the pipelined CPU.

Parameters:
REG_AW, 5, register-address width
NREG_ZERO, 0, hardwired-zero register index; never forwarded

Ports:
clk_i  input  1  clock
rst_i  input  1  reset
iss_valid_i  input  1  ID presents an instruction for transfer into EX
iss_rs_i  input  REG_AW  source A of issuing instruction
iss_rt_i  input  REG_AW  source B of issuing instruction
iss_rd_i  input  REG_AW  destination of issuing instruction
iss_regwrite_i  input  1  issuing instruction writes the register file
iss_memread_i  input  1  issuing instruction is a load
flush_i  input  1  kill instructions in ID and EX (branch taken)
hold_i  input  1  global freeze; all internal state held
stall_o  output  1  load-use stall; ID/PC must hold, EX receives a bubble
fwd_a_o  output  2  select for ALU operand A mux (instruction in EX)
fwd_b_o  output  2  select for ALU operand B mux (instruction in EX)

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-low; all state is cleared on the clk_i rising edge when rst_i=0.
- Shadow stages: EX, MEM and WB entries. Each holds {valid, rs, rt, rd, regwrite, memread}.
- Reset: all entries are invalid with zero fields. stall_o=0, fwd_a_o=0, fwd_b_o=0 from the first edge with rst_i low.
- Advance: each edge with rst_i=1 and hold_i=0:
  - WB <= MEM
  - MEM <= EX
  - EX <= issue fields, or a bubble (valid=0). EX takes a bubble when iss_valid_i=0, stall_o=1, or flush_i=1.
- flush_i: also invalidates the entry moving EX->MEM on that edge, i.e. MEM becomes a bubble.
- hold_i=1: no entry changes. Outputs are recomputed combinationally from the held state. hold_i has priority over flush_i.
- Forward select for operand A (combinational from EX, MEM, WB state):
  - fwd_a_o=1 if MEM.valid & MEM.regwrite & MEM.rd!=NREG_ZERO & MEM.rd==EX.rs.
  - Otherwise fwd_a_o=2 if the same test holds for WB.
  - Otherwise 0.
  - MEM has priority over WB when both match.
  - Value 3 is never produced.
  - fwd_b_o uses the same rule with EX.rt.
  - Both selects are 0 when EX.valid=0.
- Load-use stall (combinational): stall_o=1 iff iss_valid_i & EX.valid & EX.memread & EX.rd!=NREG_ZERO & (EX.rd==iss_rs_i | EX.rd==iss_rt_i).
- stall_o is forced 0 when flush_i=1 or rst_i=0.
- Latency:
  - Forward selects are valid in the same cycle the instruction occupies EX.
  - A load followed by a dependent instruction yields exactly one stall cycle. The dependent instruction then sees fwd=2 from WB.
- Simultaneous stall and hold: stall_o stays asserted and no bubble is inserted until hold_i drops.
- Reset mid-operation: all in-flight entries are discarded. No forward code survives reset.

Optional Feature:
- Macro: FWD_SEL_STAT_EN.
- Defined: adds output ports stat_stall_o[15:0], stat_fwd_o[15:0] and input stat_clr_i.
  - stat_stall_o counts edges with stall_o=1 and hold_i=0.
  - stat_fwd_o counts edges with hold_i=0 where fwd_a_o!=0 or fwd_b_o!=0 (max one increment per edge).
  - Both counters saturate at 16'hFFFF.
  - Both are cleared by reset or by stat_clr_i=1; clear wins over increment.
- Undefined: ports and counters are absent; the remaining behaviour is identical.

Test Plan:
- Reset: rst_i=0 for 2 edges with random inputs -> stall_o=0, fwd_a_o=0, fwd_b_o=0. After release with no issue, selects stay 0.
- EX/MEM forward: add r3<-r1,r2 then sub r4<-r3,r5 -> when sub is in EX, fwd_a_o=1 and fwd_b_o=0. Next independent instruction gives 0/0.
- MEM/WB forward and priority:
  - add r3, then nop, then or r6<-r5,r3 -> fwd_b_o=2.
  - add r3, add r3, then use r3 -> fwd=1 (MEM wins).
- Load-use: lw r7, then add r8<-r7,r7 -> stall_o=1 for exactly one cycle and a bubble enters EX. The add then gets fwd_a_o=2 and fwd_b_o=2.
- Zero register and flush:
  - Write to r0 then read r0 -> selects 0.
  - lw r7 with flush_i=1 during the dependent issue -> stall_o=0 and MEM becomes a bubble.
- Hold: hold_i=1 for 3 cycles mid-forward -> fwd values and stall_o remain constant. The pipeline resumes unchanged. With FWD_SEL_STAT_EN, counters do not increment during hold.
